// File: rtl/maxnet_controller.sv
// maxnet_controller: sequences one 4-neuron MaxNet competition with a single shared MAC
module maxnet_controller #(
  parameter int N        = 4,
  parameter int WIDTH    = 5,
  parameter int MAX_ITER = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [1:0]       x_addr,
  input  logic [WIDTH-1:0] x_data,
  output logic [3:0]       w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             busy,
  output logic             done,
  output logic             winner_valid,
  output logic [1:0]       winner_idx,
  output logic [WIDTH-1:0] winner_val,
  output logic [3:0]       iter_count,
  output logic             timeout
);
  typedef enum logic [2:0] {IDLE, LOAD, MAC, UPDATE, FINISH} state_t;
  state_t                  state_q;
  logic [1:0]              x_addr_q;
  logic [3:0]              w_addr_q;
  logic [3:0]              iter_q;
  logic                    busy_q, done_q, valid_q, timeout_q;
  logic [1:0]              idx_q;
  logic [WIDTH-1:0]        val_q;
  logic signed [WIDTH-1:0] a_q [N];
  logic signed [WIDTH-1:0] s_q [N];
  logic signed [11:0]      acc_q, acc_d, prod_x, shift_d;
  logic signed [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]        relu_d;
  logic [2:0]              nz_d;
  logic [1:0]              win_d;
  logic [1:0]              i, j;
  assign i = w_addr_q[3:2];
  assign j = w_addr_q[1:0];
  assign prod_d  = $signed(w_data) * a_q[j];
  assign prod_x  = {{2{prod_d[2*WIDTH-1]}}, prod_d};
  assign acc_d   = (j == 2'd0 ? 12'sd0 : acc_q) + prod_x;
  assign shift_d = acc_d >>> 3;
  // ReLU then saturate to the largest positive Q2.3 value
  assign relu_d  = shift_d[11] ? '0 : (|shift_d[10:4]) ? 5'd15 : {1'b0, shift_d[3:0]};
  // The shadow buffer holds the next activations, so termination and winner come from it
  always_comb begin
    nz_d  = '0;
    win_d = '0;
    for (int k = 0; k < N; k++) begin
      nz_d = nz_d + ((s_q[k] != '0) ? 3'd1 : 3'd0);
      if (s_q[k] > s_q[win_d]) win_d = 2'(k);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_addr_q  <= '0;
      w_addr_q  <= '0;
      acc_q     <= '0;
      a_q       <= '{default: '0};
      s_q       <= '{default: '0};
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      idx_q     <= '0;
      val_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= LOAD;
          busy_q    <= 1'b1;
          iter_q    <= '0;
          timeout_q <= 1'b0;
          x_addr_q  <= '0;
          w_addr_q  <= '0;
        end
        LOAD: begin
          a_q[x_addr_q] <= x_data;
          x_addr_q      <= x_addr_q + 2'd1;
          if (x_addr_q == 2'd3) state_q <= MAC;
        end
        MAC: begin
          acc_q    <= acc_d;
          w_addr_q <= w_addr_q + 4'd1;
          if (j == 2'd3) s_q[i] <= relu_d;
          if (w_addr_q == 4'd15) state_q <= UPDATE;
        end
        UPDATE: begin
          a_q    <= s_q;
          iter_q <= iter_q + 4'd1;
          if (nz_d <= 3'd1 || iter_q + 4'd1 == 4'(MAX_ITER)) begin
            state_q   <= FINISH;
            timeout_q <= nz_d > 3'd1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            valid_q   <= nz_d == 3'd1;
            idx_q     <= win_d;
            val_q     <= s_q[win_d];
          end else begin
            state_q <= MAC;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign x_addr       = x_addr_q;
  assign w_addr       = w_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign winner_valid = valid_q;
  assign winner_idx   = idx_q;
  assign winner_val   = val_q;
  assign iter_count   = iter_q;
  assign timeout      = timeout_q;
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: random and directed MaxNet runs against an iterative arithmetic model
module tb_maxnet_controller;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  always #5 clk = ~clk;
  logic signed [4:0] xm [4];
  logic signed [4:0] wm [16];
  logic [1:0] x_addr [2];
  logic [4:0] x_data [2];
  logic [3:0] w_addr [2];
  logic [4:0] w_data [2];
  logic       busy [2], done [2], wv [2], tmo [2];
  logic [1:0] widx [2];
  logic [4:0] wval [2];
  logic [3:0] itc [2];
  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign x_data[g] = xm[x_addr[g]];
    assign w_data[g] = wm[w_addr[g]];
  end
  maxnet_controller #(.MAX_ITER(15)) u0 (
    .clk(clk), .rst(rst), .start(start), .x_addr(x_addr[0]), .x_data(x_data[0]),
    .w_addr(w_addr[0]), .w_data(w_data[0]), .busy(busy[0]), .done(done[0]),
    .winner_valid(wv[0]), .winner_idx(widx[0]), .winner_val(wval[0]),
    .iter_count(itc[0]), .timeout(tmo[0]));
  maxnet_controller #(.MAX_ITER(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .x_addr(x_addr[1]), .x_data(x_data[1]),
    .w_addr(w_addr[1]), .w_data(w_data[1]), .busy(busy[1]), .done(done[1]),
    .winner_valid(wv[1]), .winner_idx(widx[1]), .winner_val(wval[1]),
    .iter_count(itc[1]), .timeout(tmo[1]));
  int vectors = 0, miscompares = 0;
  int n = -1;
  bit active = 1'b0;
  int e_it [2], e_to [2], e_idx [2], e_val [2], e_vld [2], e_d [2], dones [2];
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Whole-run reference: plain integer matrix-vector iterations with floor/ReLU/saturation
  function automatic void model(input int xs [4], input int ws [16], input int mi,
                                output int it, output int to, output int idx,
                                output int val, output int vld);
    int a [4], s [4], acc, q, nz;
    a = xs; it = 0; to = 0; nz = 0;
    forever begin
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int c = 0; c < 4; c++) acc += ws[4*r+c] * a[c];
        q = acc >= 0 ? acc / 8 : -((-acc + 7) / 8);
        s[r] = q < 0 ? 0 : q > 15 ? 15 : q;
      end
      a = s; it++; nz = 0;
      for (int r = 0; r < 4; r++) if (a[r] != 0) nz++;
      if (nz <= 1) break;
      if (it == mi) begin to = 1; break; end
    end
    idx = 0;
    for (int r = 1; r < 4; r++) if (a[r] > a[idx]) idx = r;
    val = a[idx]; vld = (nz == 1) ? 1 : 0;
  endfunction
  always @(negedge clk) if (active) begin
    n++;
    for (int d = 0; d < 2; d++) begin
      if (n == 0) begin
        chk($sformatf("u%0d idle busy", d), int'(busy[d]), 0);
        chk($sformatf("u%0d idle done", d), int'(done[d]), 0);
      end else if (n < e_d[d]) begin
        chk($sformatf("u%0d busy n=%0d", d, n), int'(busy[d]), 1);
        chk($sformatf("u%0d done n=%0d", d, n), int'(done[d]), 0);
        if (n <= 4) chk($sformatf("u%0d x_addr n=%0d", d, n), int'(x_addr[d]), n - 1);
        if (n >= 5 && (n - 5) % 17 < 16)
          chk($sformatf("u%0d w_addr n=%0d", d, n), int'(w_addr[d]), (n - 5) % 17);
      end else begin
        chk($sformatf("u%0d busy n=%0d", d, n), int'(busy[d]), 0);
        chk($sformatf("u%0d done n=%0d", d, n), int'(done[d]), n == e_d[d] ? 1 : 0);
        chk($sformatf("u%0d winner_valid", d), int'(wv[d]), e_vld[d]);
        chk($sformatf("u%0d winner_idx", d), int'(widx[d]), e_idx[d]);
        chk($sformatf("u%0d winner_val", d), int'(wval[d]), e_val[d]);
        chk($sformatf("u%0d iter_count", d), int'(itc[d]), e_it[d]);
        chk($sformatf("u%0d timeout", d), int'(tmo[d]), e_to[d]);
      end
      if (n > 0 && done[d]) dones[d]++;
    end
  end
  task automatic run(input int xs [4], input int ws [16], input bit spam);
    int mind, maxd, guard;
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) xm[k] = 5'(xs[k]);
    for (int k = 0; k < 16; k++) wm[k] = 5'(ws[k]);
    model(xs, ws, 15, e_it[0], e_to[0], e_idx[0], e_val[0], e_vld[0]);
    model(xs, ws, 1, e_it[1], e_to[1], e_idx[1], e_val[1], e_vld[1]);
    for (int d = 0; d < 2; d++) begin e_d[d] = 5 + 17 * e_it[d]; dones[d] = 0; end
    mind = e_d[0] < e_d[1] ? e_d[0] : e_d[1];
    maxd = e_d[0] > e_d[1] ? e_d[0] : e_d[1];
    n = -1; active = 1'b1; start = 1'b1; guard = 0;
    while (n < maxd + 1 && guard < 600) begin
      @(posedge clk); #2;
      start = spam && n < mind;
      guard++;
    end
    active = 1'b0; start = 1'b0;
    if (guard >= 600) chk("run cycle bound", n, maxd + 1);
    for (int d = 0; d < 2; d++) chk($sformatf("u%0d done pulses", d), dones[d], 1);
  endtask
  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s u%0d busy", tag, d), int'(busy[d]), 0);
      chk($sformatf("%s u%0d done", tag, d), int'(done[d]), 0);
      chk($sformatf("%s u%0d winner_valid", tag, d), int'(wv[d]), 0);
      chk($sformatf("%s u%0d winner_idx", tag, d), int'(widx[d]), 0);
      chk($sformatf("%s u%0d winner_val", tag, d), int'(wval[d]), 0);
      chk($sformatf("%s u%0d iter_count", tag, d), int'(itc[d]), 0);
      chk($sformatf("%s u%0d timeout", tag, d), int'(tmo[d]), 0);
      chk($sformatf("%s u%0d x_addr", tag, d), int'(x_addr[d]), 0);
      chk($sformatf("%s u%0d w_addr", tag, d), int'(w_addr[d]), 0);
    end
  endtask
  initial begin
    int wd [16], wr [16], xr [4];
    int x2 [4] = '{8, 6, 4, 2};
    int x3 [4] = '{4, 4, 4, 4};
    int x5 [4] = '{2, 2, 15, 1};
    for (int k = 0; k < 16; k++) wd[k] = (k / 4 == k % 4) ? 8 : -2;
    for (int k = 0; k < 4; k++) xm[k] = '0;
    for (int k = 0; k < 16; k++) wm[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    #2 rst = 1'b0;
    run(x2, wd, 1'b0);
    chk("pin x8642 latency", e_d[0] + 1, 40);
    chk("pin x8642 iters", e_it[0], 2);
    chk("pin x8642 value", e_val[0], 4);
    chk("pin x8642 valid", e_vld[0], 1);
    chk("pin cap1 timeout", e_to[1], 1);
    chk("pin cap1 value", e_val[1], 5);
    chk("pin cap1 valid", e_vld[1], 0);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("midrun reset");
    #2 rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("post reset u%0d done", d), int'(done[d]), 0);
        chk($sformatf("post reset u%0d busy", d), int'(busy[d]), 0);
      end
    end
    run(x3, wd, 1'b0);
    chk("pin x4444 iters", e_it[0], 2);
    chk("pin x4444 valid", e_vld[0], 0);
    chk("pin x4444 value", e_val[0], 0);
    run(x5, wd, 1'b0);
    chk("pin x2 2 15 1 idx", e_idx[0], 2);
    chk("pin x2 2 15 1 value", e_val[0], 13);
    chk("pin x2 2 15 1 valid", e_vld[0], 1);
    run(x2, wd, 1'b1);
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 4; k++) xr[k] = int'($urandom_range(0, 31)) - 16;
      for (int k = 0; k < 16; k++)
        wr[k] = (r % 2 == 0) ? ((k / 4 == k % 4) ? int'($urandom_range(8, 15)) : -int'($urandom_range(0, 6)))
                             : int'($urandom_range(0, 31)) - 16;
      run(xr, wr, r % 5 == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/maxnet_controller.md
Name: maxnet_controller

Overview:
- Sequences one MaxNet competition over the 4-neuron, 5-bit fixed-point network.
- Loads the 4 initial activations from the input store, then iterates activations a' = ReLU(W·a) using the 4x4 weight store. One shared multiply-accumulate handles one weight per cycle.
- Stops when at most one neuron remains non-zero, or when an iteration cap is reached.
- Reports the winning neuron, its value and the iteration count to the top-level FSM.

Parameters:
N, 4, number of neurons (fixed at 4; address widths below assume it)
WIDTH, 5, activation/weight width, signed Q2.3 (01000 = 1.0, 11110 = -0.25)
MAX_ITER, 15, iteration cap, range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a competition; sampled only in IDLE
x_addr  output  2  input-store read address
x_data  input  5  input-store read data, combinational from x_addr in the same cycle
w_addr  output  4  weight-store read address = 4*i + j
w_data  input  5  weight-store read data, combinational from w_addr in the same cycle
busy  output  1  high from the cycle after start accepted until done
done  output  1  one-cycle pulse when result outputs become valid
winner_valid  output  1  1 if exactly one neuron is non-zero at termination
winner_idx  output  2  index of the largest final activation (lowest index on tie)
winner_val  output  5  final activation of winner_idx
iter_count  output  4  number of completed iterations
timeout  output  1  1 if stopped by MAX_ITER, not by convergence

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; x_addr = 0, w_addr = 0; activations, shadow buffer, accumulator and counters cleared. Reset mid-run aborts with no done pulse.
- States: IDLE -> LOAD -> MAC -> UPDATE -> (MAC | FINISH) -> IDLE.
- IDLE: start = 1 -> LOAD, busy = 1 next cycle, iter_count and timeout cleared. Result outputs hold their previous values until the next done.
- LOAD: 4 cycles. Cycle k drives x_addr = k and captures a[k] = x_data. After k = 3 -> MAC with i = 0, j = 0.
- MAC: 16 cycles, one per (i, j), j inner.
  - Drive w_addr = {i, j}.
  - Product = signed w_data × signed a[j] (10-bit); sign-extend and accumulate into a 12-bit signed accumulator. The accumulator is reset at j = 0.
  - At j = 3: shift = acc >>> 3 (arithmetic, floor); result = 0 if shift < 0, 15 if shift > 15, else shift. Write result to shadow s[i].
  - Activations a[] are NOT modified during MAC (synchronous update).
- UPDATE: 1 cycle.
  - a[] <= s[], iter_count += 1.
  - nz = number of non-zero s[].
  - If nz <= 1 -> FINISH with timeout = 0.
  - Else if the new iter_count == MAX_ITER -> FINISH with timeout = 1.
  - Else -> MAC.
- FINISH: 1 cycle.
  - winner_idx / winner_val = max of a[] (lowest index on tie).
  - winner_valid = (nz == 1).
  - done = 1, busy = 0; next state IDLE.
  - All-zero result: winner_valid = 0, winner_idx = 0, winner_val = 0.
- Latency start -> done: 1 + 4 + 17·iterations + 1 cycles. For example, 2 iterations gives done in the 40th cycle after start is sampled.
- start while busy: ignored. start in the same cycle as done: ignored, since the FSM is not in IDLE. Back-to-back runs need start in a later IDLE cycle.
- Negative x_data values are loaded unchanged; ReLU applies only to computed results.

Test Plan:
1. Reset: hold rst 2 cycles mid-MAC -> busy = 0, done never pulses, all outputs 0; a later start runs normally.
2. X = {8,6,4,2}, default diagonal-8 / off-diagonal -2 weights.
   - After iteration 1: a = {5,2,0,0}. After iteration 2: a = {4,0,0,0}.
   - done in the 40th cycle after start; winner_valid = 1, winner_idx = 0, winner_val = 4, iter_count = 2, timeout = 0.
3. X = {4,4,4,4}.
   - After iteration 1: a = {1,1,1,1}. After iteration 2: all zero.
   - done with winner_valid = 0, winner_idx = 0, winner_val = 0, iter_count = 2.
4. MAX_ITER = 1, X = {8,6,4,2} -> timeout = 1, iter_count = 1, winner_idx = 0, winner_val = 5, winner_valid = 0.
5. X = {2,2,15,1}: check saturation and clamp arithmetic against the reference model, including ReLU clamping of the negative sums. Final winner_idx = 2, winner_valid = 1.
6. Pulse start every cycle during a run -> exactly one done; x_addr/w_addr sequences are 0..3 then 0..15 per iteration, never restarted.
